// File: rtl/sram_arb_pkg.sv
// Shared sizing and state encoding for the SRAM arbiter slice.
package sram_arb_pkg;

    localparam int ADDR_W = 11;    // SRAM word address width
    localparam int DATA_W = 128;   // SRAM word width
    localparam int DEPTH  = 2048;  // number of SRAM words

    // SERVE: arbitrate loader/corelet requests; CLEAR: sweep zeros into the SRAM
    typedef enum logic {
        ST_SERVE = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/sram_rr_arb.sv
// Two-port round-robin grant. The grant is combinational so the caller can
// use it directly as req_ready; the preference pointer moves only when a
// grant is actually given.
module sram_rr_arb (
    input  logic       clk,
    input  logic       reset,      // synchronous, active-low
    input  logic       enable,     // grants allowed this cycle
    input  logic [1:0] req_valid,
    output logic [1:0] grant
);

    logic rr_reg;   // port preferred when both request (0 after reset)
    logic rr_next;

    // Grant: single requester wins outright, contention goes to the preferred port
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req_valid == 2'b11) begin
                grant = rr_reg ? 2'b10 : 2'b01;
            end else begin
                grant = req_valid;
            end
        end
    end

    // Pointer: after a grant, prefer the other port next time
    always_comb begin
        rr_next = rr_reg;
        if (grant[0]) begin
            rr_next = 1'b1;
        end else if (grant[1]) begin
            rr_next = 1'b0;
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_reg <= 1'b0;
        end else begin
            rr_reg <= rr_next;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port SRAM front end: round-robin access for loader (port 0) and corelet
// (port 1), registered SRAM control, a two-stage read response pipeline and a
// whole-array clear sequencer.
module sram_arbiter #(
    parameter int ADDR_W = sram_arb_pkg::ADDR_W,
    parameter int DATA_W = sram_arb_pkg::DATA_W,
    parameter int DEPTH  = sram_arb_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,       // synchronous, active-low
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_wr,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              CEN,
    output logic              WEN,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    input  logic [DATA_W-1:0] Q
);

    import sram_arb_pkg::*;

    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              cen_reg, cen_next;
    logic              wen_reg, wen_next;
    logic [ADDR_W-1:0] a_reg, a_next;
    logic [DATA_W-1:0] d_reg, d_next;
    logic              clr_done_reg, clr_done_next;

    logic [1:0]        grant;
    logic              accept;
    logic              acc_wr;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;

    sram_rr_arb u_rr_arb (
        .clk       (clk),
        .reset     (reset),
        .enable    (state_reg == ST_SERVE),
        .req_valid (req_valid),
        .grant     (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign acc_wr    = grant[1] ? req_wr[1]  : req_wr[0];
    assign acc_addr  = grant[1] ? req_addr1  : req_addr0;
    assign acc_data  = grant[1] ? req_data1  : req_data0;

    // Next state and next SRAM command; idle cycles park the bus at zero
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        cen_next      = 1'b1;
        wen_next      = 1'b1;
        a_next        = '0;
        d_next        = '0;
        clr_done_next = 1'b0;
        case (state_reg)
            ST_SERVE: begin
                // A request in the same cycle as clr_start is still served
                if (accept) begin
                    cen_next = 1'b0;
                    wen_next = ~acc_wr;
                    a_next   = acc_addr;
                    d_next   = acc_wr ? acc_data : '0;
                end
                if (clr_start) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            ST_CLEAR: begin
                cen_next = 1'b0;
                wen_next = 1'b0;
                a_next   = cnt_reg;
                if (cnt_reg == CNT_LAST) begin
                    state_next    = ST_SERVE;
                    cnt_next      = '0;
                    clr_done_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + ADDR_W'(1);
                end
            end
            default: begin
                state_next = ST_SERVE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, clear counter and registered SRAM command
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= ST_SERVE;
            cnt_reg      <= '0;
            cen_reg      <= 1'b1;
            wen_reg      <= 1'b1;
            a_reg        <= '0;
            d_reg        <= '0;
            clr_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            cen_reg      <= cen_next;
            wen_reg      <= wen_next;
            a_reg        <= a_next;
            d_reg        <= d_next;
            clr_done_reg <= clr_done_next;
        end
    end

    // Per-port read tag: stage 1 tracks the command cycle, stage 2 the Q cycle
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp_tag
        logic tag1_reg;
        logic tag2_reg;
        // Tag pipeline for port gi
        always_ff @(posedge clk) begin
            if (!reset) begin
                tag1_reg <= 1'b0;
                tag2_reg <= 1'b0;
            end else begin
                tag1_reg <= grant[gi] & ~req_wr[gi];
                tag2_reg <= tag1_reg;
            end
        end
        assign rsp_valid[gi] = tag2_reg;
    end

    assign rsp_data = (|rsp_valid) ? Q : '0;
    assign clr_busy = (state_reg == ST_CLEAR);
    assign clr_done = clr_done_reg;
    assign CEN      = cen_reg;
    assign WEN      = wen_reg;
    assign A        = a_reg;
    assign D        = d_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural SRAM and a response
// scoreboard keyed on port tag, data and latency.
module tb_sram_arbiter;

    localparam int AW    = 11;
    localparam int DW    = 128;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid, req_ready, req_wr, rsp_valid;
    logic [AW-1:0] req_addr0, req_addr1, A;
    logic [DW-1:0] req_data0, req_data1, rsp_data, D, Q;
    logic          clr_start, clr_busy, clr_done, CEN, WEN;

    sram_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_data0(req_data0), .req_data1(req_data1),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .CEN(CEN), .WEN(WEN), .A(A), .D(D), .Q(Q)
    );

    always #5 clk = ~clk;

    // Behavioural single-port synchronous SRAM
    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] q_reg;
    always @(posedge clk) begin
        if (!CEN) begin
            if (!WEN) mem[A] <= D;
            else      q_reg <= mem[A];
        end
    end
    assign Q = q_reg;

    typedef struct {
        logic [1:0]    tag;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] shadow [0:DEPTH-1];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            done_cnt = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Response monitor: every rsp_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (clr_done === 1'b1) done_cnt++;
        if (rsp_valid !== 2'b00) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", {126'd0, rsp_valid}, '0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("rsp tag=%b data=%h cyc=%0d", rsp_valid, rsp_data, cyc);
                check("rsp_tag", {126'd0, rsp_valid}, {126'd0, e.tag});
                check("rsp_data", rsp_data, e.data);
                check("rsp_latency", DW'(cyc - e.cyc), DW'(2));
            end
        end
    end

    // Drive one request on port p until accepted, then check the SRAM command
    task automatic issue(input int p, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int   waited = 0;
        logic got;
        if (p == 0) begin req_addr0 = addr; req_data0 = data; end
        else        begin req_addr1 = addr; req_data1 = data; end
        req_wr[p]    = wr;
        req_valid[p] = 1'b1;
        @(negedge clk);
        while (req_ready[p] !== 1'b1 && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        got = (req_ready[p] === 1'b1);
        if (!got) begin
            check("accept_timeout", 0, 1);
        end else begin
            $display("req port=%0d wr=%0b addr=%0d data=%h cyc=%0d", p, wr, addr, data, cyc);
            if (wr) shadow[addr] = data;
            else    sb.push_back('{tag: (p == 0) ? 2'b01 : 2'b10, data: shadow[addr], cyc: cyc});
        end
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        @(negedge clk);
        if (got) begin
            check("cmd_cen", {127'd0, CEN}, '0);
            check("cmd_wen", {127'd0, WEN}, {127'd0, ~wr});
            check("cmd_a", {117'd0, A}, {117'd0, addr});
            check("cmd_d", D, wr ? data : '0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int            busy_cnt, m, sweep_err, ready_err, waited;
        logic [DW-1:0] pat;
        logic [1:0]    exp_g;

        reset = 1'b0; req_valid = 2'b00; req_wr = 2'b00; clr_start = 1'b0;
        req_addr0 = '0; req_addr1 = '0; req_data0 = '0; req_data1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cen", {127'd0, CEN}, {127'd0, 1'b1});
        check("rst_wen", {127'd0, WEN}, {127'd0, 1'b1});
        check("rst_a", {117'd0, A}, '0);
        check("rst_d", D, '0);
        check("rst_rsp_valid", {126'd0, rsp_valid}, '0);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_clr_busy", {127'd0, clr_busy}, '0);
        check("rst_clr_done", {127'd0, clr_done}, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Preload a few words through both ports
        issue(0, 1'b1, 11'd0,    {$urandom, $urandom, $urandom, $urandom});
        issue(0, 1'b1, 11'd1,    {$urandom, $urandom, $urandom, $urandom});
        issue(1, 1'b1, 11'd7,    {$urandom, $urandom, $urandom, $urandom});
        issue(1, 1'b1, 11'd2047, {$urandom, $urandom, $urandom, $urandom});
        issue(1, 1'b1, 11'd2,    {$urandom, $urandom, $urandom, $urandom});

        // Loader writes 0xAA.. to 5, corelet reads it back
        pat = {32{4'hA}};
        issue(0, 1'b1, 11'd5, pat);
        issue(1, 1'b0, 11'd5, '0);
        issue(0, 1'b0, 11'd1, '0);
        issue(1, 1'b0, 11'd2047, '0);

        // Both ports hold reads for four cycles: grants alternate 0,1,0,1
        req_addr0 = 11'd1; req_addr1 = 11'd2; req_wr = 2'b00; req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            check("rr_grant", {126'd0, req_ready}, {126'd0, exp_g});
            sb.push_back('{tag: exp_g, data: shadow[(k % 2 == 0) ? 1 : 2], cyc: cyc});
            if (k > 0) check("b2b_a", {117'd0, A}, (k % 2 == 1) ? DW'(1) : DW'(2));
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        repeat (4) @(posedge clk); #1;

        // Read of addr 7 together with clr_start, then corelet waits through the clear
        req_addr0 = 11'd7; req_wr[0] = 1'b0; req_valid[0] = 1'b1; clr_start = 1'b1;
        @(negedge clk);
        check("clr_same_cycle_ready", {126'd0, req_ready}, {126'd0, 2'b01});
        sb.push_back('{tag: 2'b01, data: shadow[7], cyc: cyc});
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        @(posedge clk); #1;
        req_valid[0] = 1'b0; clr_start = 1'b0;
        req_addr1 = 11'd2047; req_wr[1] = 1'b0; req_valid[1] = 1'b1;
        @(negedge clk);
        check("clr_busy_t1", {127'd0, clr_busy}, {127'd0, 1'b1});
        check("clr_t1_read_cmd", {117'd0, WEN, A}, {117'd0, 1'b1, 11'd7});
        busy_cnt = 1; m = 1; sweep_err = 0; ready_err = 0;
        while (m < 5000) begin
            @(negedge clk);
            if (clr_busy !== 1'b1) break;
            busy_cnt++;
            if (CEN !== 1'b0 || WEN !== 1'b0 || D !== '0 || A !== AW'(m - 1)) sweep_err++;
            if (req_ready !== 2'b00) ready_err++;
            if (clr_done !== 1'b0) sweep_err++;
            m++;
        end
        $display("clear busy_cnt=%0d cyc=%0d", busy_cnt, cyc);
        check("clr_busy_cycles", DW'(busy_cnt), DW'(DEPTH));
        check("clr_sweep_errs", DW'(sweep_err), '0);
        check("clr_ready_blocked", DW'(ready_err), '0);
        check("clr_last_a", {117'd0, A}, DW'(DEPTH - 1));
        check("clr_last_wen", {127'd0, WEN}, '0);
        check("clr_done_pulse", {127'd0, clr_done}, {127'd0, 1'b1});
        check("ready_after_clear", {126'd0, req_ready}, {126'd0, 2'b10});
        sb.push_back('{tag: 2'b10, data: shadow[2047], cyc: cyc});
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("clr_done_once", {127'd0, clr_done}, '0);
        check("post_clr_cmd", {116'd0, CEN, WEN, A}, {116'd0, 1'b0, 1'b1, 11'd2047});
        @(posedge clk); #1;
        issue(0, 1'b0, 11'd0, '0);
        repeat (4) @(posedge clk); #1;

        // Reset while the clear sweep is at address 100
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        waited = 0;
        @(negedge clk);
        while (!(clr_busy === 1'b1 && A === 11'd100) && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check("clr_reach_100", {117'd0, A}, DW'(100));
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_cen", {127'd0, CEN}, {127'd0, 1'b1});
        check("rst_mid_wen", {127'd0, WEN}, {127'd0, 1'b1});
        check("rst_mid_a", {117'd0, A}, '0);
        check("rst_mid_busy", {127'd0, clr_busy}, '0);
        check("rst_mid_done", {127'd0, clr_done}, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (20) @(posedge clk); #1;

        // Reset with a read in flight: no response may follow
        req_addr0 = 11'd3; req_wr[0] = 1'b0; req_valid[0] = 1'b1;
        @(negedge clk);
        check("inflight_ready", {126'd0, req_ready}, {126'd0, 2'b01});
        @(posedge clk); #1;
        req_valid[0] = 1'b0; reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("inflight_rsp_valid", {126'd0, rsp_valid}, '0);
        check("inflight_rsp_data", rsp_data, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);

        check("sb_empty", DW'(sb.size()), '0);
        check("clr_done_total", DW'(done_cnt), DW'(1));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
